pipeline_sequencer: RTL
=======================

# pipeline_sequencer

Central pipeline controller for the four-stage processor (IR1 fetch, IR2 decode/register-read, IR3 execute, IR4 write-back). It generates the fetch enable consumed by the fetch-stage control and the load, squash and bubble strobes for IR2–IR4. It detects read-after-write hazards and flushes wrong-path instructions after a taken branch. It also drains the pipeline on `stop` and keeps saturating stall and flush counters.

## Interface
Parameters:
- `REG_W`, 2: register-index width (4 registers).
- `FLUSH_EXTRA`, 1: extra squash cycles after the branch cycle.
- `DRAIN_CYCLES`, 2: cycles allowed for IR3/IR4 to retire after `stop` is accepted.
- `CNT_W`, 16: width of the performance counters.

Ports:
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `ir2_op`  in  4  opcode in IR2.
- `ir2_ra`, `ir2_rb`  in  REG_W  register fields in IR2.
- `ir3_wr_en`, `ir4_wr_en`  in  1  IR3/IR4 instruction writes the register file.
- `ir3_wd`, `ir4_wd`  in  REG_W  destination register of IR3/IR4.
- `branch_taken`  in  1  execute stage resolved a taken branch this cycle.
- `en_fetch`  out  1  fetch stage may advance PC/IR1.
- `ir2_load`, `ir3_load`, `ir4_load`  out  1  stage register load enables.
- `ir2_squash`  out  1  IR2 loads NOP instead of IR1.
- `ir3_bubble`  out  1  IR3 loads NOP instead of IR2.
- `halted`  out  1  pipeline stopped.
- `stall_count`, `flush_count`  out  CNT_W  saturating event counters.

## Operation
- States: RUN, FLUSH, DRAIN, HALT. Reset enters RUN, clears counters and clears the flush/drain counter.
- Read-use decode of `ir2_op`:
  - add, subtract, nand, store read ra and rb.
  - load reads rb.
  - shift reads ra.
  - ori reads R1.
  - branches, nop and stop read nothing.
- Hazard condition: a register read by IR2 equals `ir3_wd` with `ir3_wr_en` set, or equals `ir4_wd` with `ir4_wr_en` set. There is no forwarding.
- Flag hazards do not exist: flags update at the end of execute.
- RUN, per cycle, in priority order:
  - `branch_taken`: `ir2_squash`=1, all loads=1, `en_fetch`=1. Go to FLUSH with count=FLUSH_EXTRA; `flush_count`++.
  - Hazard: `en_fetch`=0, `ir2_load`=0, `ir3_bubble`=1, `ir3_load`=`ir4_load`=1; `stall_count`++.
  - `ir2_op`==stop: `en_fetch`=0, `ir2_squash`=1, loads=1. Go to DRAIN with count=DRAIN_CYCLES.
  - Otherwise all loads=1, `en_fetch`=1, no squash or bubble.
- FLUSH: `ir2_squash`=1, loads=1, `en_fetch`=1; hazard and stop checks are ignored. The count decrements and the state returns to RUN when the count reaches 0. A new `branch_taken` reloads the count and increments `flush_count`.
- DRAIN: `en_fetch`=0, `ir2_squash`=1, loads=1. Decrement; at 0 go to HALT.
- HALT: all outputs 0 except `halted`=1. The only exit is `reset`.
- Counters saturate at all-ones; they are never cleared except by reset.
- Simultaneous `branch_taken` and stop in IR2: the branch wins, so the stop is wrong-path and is squashed.
- Simultaneous `branch_taken` and hazard: the branch wins and no stall is counted.

## Timing
- Strobes are combinational from the current state and the same-cycle inputs. State and counters are registered.
- Reset cycle and the state after reset: all strobes 0 during the cycle `reset` is high. `halted`=0 and counters=0 after the edge. The first cycle after reset deasserts is RUN.
- Stall lasts exactly as long as the hazard persists: one cycle per IR3 dependency plus one per IR4 dependency. Worst case is 2 cycles per instruction.
- Taken branch costs 1+FLUSH_EXTRA squashed IR2 slots.
- `halted` rises DRAIN_CYCLES+1 cycles after stop is seen in IR2.
- Reset mid-FLUSH or mid-DRAIN: RUN on the next cycle with no residual count.

## Structure
- Shared package `cpu_pkg`:
  - opcode constants: load=0, stop=1, store=2, shift=3 (3-bit), add=4, bz=5, subtract=6, ori=7 (3-bit), nand=8, bnz=9, nop=10, bpz=13.
  - state enum.
  - `REG_W`.
- Combinational sub-module `hazard_detect`: read-use decode plus the two destination compares, outputs `hazard`.
- Top level holds the FSM, the flush/drain counter and the performance counters.

## Test plan
- Independent add R0,R1 then add R2,R3 → no stall, `stall_count`=0, `en_fetch` high every cycle.
- load R1 (IR3, `ir3_wd`=1) with add R2,R1 in IR2 → 2 stall cycles with `ir3_bubble`=1, then advance; `stall_count`=2.
- `branch_taken` in RUN → `ir2_squash`=1 for 2 consecutive cycles; `flush_count`=1; back to RUN on the 3rd cycle.
- stop in IR2 → `en_fetch`=0 immediately; `halted`=1 on the 3rd edge; all strobes 0 thereafter.
- stop in IR2 with `branch_taken` in the same cycle → FLUSH, no halt; execution continues.
- Force `stall_count` to all-ones then trigger another stall → stays at all-ones; `reset` asserted in DRAIN → RUN, counters 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, sequencer state and read-use decode
package cpu_pkg;

  localparam int REG_W = 2;

  localparam logic [3:0] OP_LOAD  = 4'd0;
  localparam logic [3:0] OP_STOP  = 4'd1;
  localparam logic [3:0] OP_STORE = 4'd2;
  localparam logic [3:0] OP_SHIFT = 4'd3;
  localparam logic [3:0] OP_ADD   = 4'd4;
  localparam logic [3:0] OP_BZ    = 4'd5;
  localparam logic [3:0] OP_SUB   = 4'd6;
  localparam logic [3:0] OP_ORI   = 4'd7;
  localparam logic [3:0] OP_NAND  = 4'd8;
  localparam logic [3:0] OP_BNZ   = 4'd9;
  localparam logic [3:0] OP_NOP   = 4'd10;
  localparam logic [3:0] OP_BPZ   = 4'd13;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HALT  = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic ra;
    logic rb;
    logic r1;
  } read_use_t;

  // ori implicitly reads R1; branches, nop and stop read no registers.
  function automatic read_use_t decode_read_use(input logic [3:0] op);
    read_use_t use_q;
    use_q = '0;
    case (op)
      OP_ADD, OP_SUB, OP_NAND, OP_STORE: begin
        use_q.ra = 1'b1;
        use_q.rb = 1'b1;
      end
      OP_LOAD:  use_q.rb = 1'b1;
      OP_SHIFT: use_q.ra = 1'b1;
      OP_ORI:   use_q.r1 = 1'b1;
      default:  use_q = '0;
    endcase
    return use_q;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - read-after-write hazard check of IR2 against IR3/IR4
module hazard_detect
  import cpu_pkg::*;
#(
  parameter int REG_W = cpu_pkg::REG_W
) (
  input  logic [3:0]       op,
  input  logic [REG_W-1:0] ra,
  input  logic [REG_W-1:0] rb,
  input  logic             ir3_wr_en,
  input  logic [REG_W-1:0] ir3_wd,
  input  logic             ir4_wr_en,
  input  logic [REG_W-1:0] ir4_wd,
  output logic             hazard
);

  localparam logic [REG_W-1:0] REG_R1 = REG_W'(1);

  read_use_t read_use;
  logic      ra_hit;
  logic      rb_hit;
  logic      r1_hit;

  // No forwarding: any pending write to a read register blocks IR2.
  assign read_use = decode_read_use(op);
  assign ra_hit   = (ir3_wr_en && (ir3_wd == ra)) || (ir4_wr_en && (ir4_wd == ra));
  assign rb_hit   = (ir3_wr_en && (ir3_wd == rb)) || (ir4_wr_en && (ir4_wd == rb));
  assign r1_hit   = (ir3_wr_en && (ir3_wd == REG_R1)) || (ir4_wr_en && (ir4_wd == REG_R1));

  assign hazard = (read_use.ra && ra_hit) || (read_use.rb && rb_hit) || (read_use.r1 && r1_hit);

endmodule

// File: rtl/pipeline_sequencer.sv
// rtl/pipeline_sequencer.sv - four-stage pipeline control FSM with stall/flush counters
module pipeline_sequencer
  import cpu_pkg::*;
#(
  parameter int REG_W        = cpu_pkg::REG_W,
  parameter int FLUSH_EXTRA  = 1,
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [3:0]       ir2_op,
  input  logic [REG_W-1:0] ir2_ra,
  input  logic [REG_W-1:0] ir2_rb,
  input  logic             ir3_wr_en,
  input  logic             ir4_wr_en,
  input  logic [REG_W-1:0] ir3_wd,
  input  logic [REG_W-1:0] ir4_wd,
  input  logic             branch_taken,
  output logic             en_fetch,
  output logic             ir2_load,
  output logic             ir3_load,
  output logic             ir4_load,
  output logic             ir2_squash,
  output logic             ir3_bubble,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int MAX_SEQ = (FLUSH_EXTRA > DRAIN_CYCLES) ? FLUSH_EXTRA : DRAIN_CYCLES;
  localparam int SEQ_W   = (MAX_SEQ < 2) ? 1 : $clog2(MAX_SEQ + 1);

  localparam logic [SEQ_W-1:0] SEQ_FLUSH = SEQ_W'(FLUSH_EXTRA);
  localparam logic [SEQ_W-1:0] SEQ_DRAIN = SEQ_W'(DRAIN_CYCLES);
  localparam logic [SEQ_W-1:0] SEQ_ONE   = SEQ_W'(1);

  seq_state_t       state;
  seq_state_t       next_state;
  logic [SEQ_W-1:0] seq_cnt;
  logic [SEQ_W-1:0] seq_cnt_next;
  logic             hazard;
  logic             stall_inc;
  logic             flush_inc;

  hazard_detect #(
    .REG_W(REG_W)
  ) u_hazard_detect (
    .op       (ir2_op),
    .ra       (ir2_ra),
    .rb       (ir2_rb),
    .ir3_wr_en(ir3_wr_en),
    .ir3_wd   (ir3_wd),
    .ir4_wr_en(ir4_wr_en),
    .ir4_wd   (ir4_wd),
    .hazard   (hazard)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_RUN;
      seq_cnt     <= '0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      state   <= next_state;
      seq_cnt <= seq_cnt_next;
      if (stall_inc && (stall_count != '1)) stall_count <= stall_count + CNT_W'(1);
      if (flush_inc && (flush_count != '1)) flush_count <= flush_count + CNT_W'(1);
    end
  end

  // Strobes are held low for the whole reset cycle regardless of state.
  always_comb begin
    next_state   = state;
    seq_cnt_next = seq_cnt;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;
    en_fetch     = 1'b0;
    ir2_load     = 1'b0;
    ir3_load     = 1'b0;
    ir4_load     = 1'b0;
    ir2_squash   = 1'b0;
    ir3_bubble   = 1'b0;
    halted       = 1'b0;
    if (!reset) begin
      case (state)
        ST_RUN: begin
          if (branch_taken) begin
            {en_fetch, ir2_load, ir3_load, ir4_load, ir2_squash} = 5'b11111;
            flush_inc    = 1'b1;
            seq_cnt_next = SEQ_FLUSH;
            next_state   = (FLUSH_EXTRA == 0) ? ST_RUN : ST_FLUSH;
          end else if (hazard) begin
            ir3_bubble = 1'b1;
            ir3_load   = 1'b1;
            ir4_load   = 1'b1;
            stall_inc  = 1'b1;
          end else if (ir2_op == OP_STOP) begin
            {ir2_load, ir3_load, ir4_load, ir2_squash} = 4'b1111;
            seq_cnt_next = SEQ_DRAIN;
            next_state   = (DRAIN_CYCLES == 0) ? ST_HALT : ST_DRAIN;
          end else begin
            {en_fetch, ir2_load, ir3_load, ir4_load} = 4'b1111;
          end
        end
        ST_FLUSH: begin
          {en_fetch, ir2_load, ir3_load, ir4_load, ir2_squash} = 5'b11111;
          if (branch_taken) begin
            flush_inc    = 1'b1;
            seq_cnt_next = SEQ_FLUSH;
            next_state   = (FLUSH_EXTRA == 0) ? ST_RUN : ST_FLUSH;
          end else if (seq_cnt <= SEQ_ONE) begin
            seq_cnt_next = '0;
            next_state   = ST_RUN;
          end else begin
            seq_cnt_next = seq_cnt - SEQ_ONE;
          end
        end
        ST_DRAIN: begin
          {ir2_load, ir3_load, ir4_load, ir2_squash} = 4'b1111;
          if (seq_cnt <= SEQ_ONE) begin
            seq_cnt_next = '0;
            next_state   = ST_HALT;
          end else begin
            seq_cnt_next = seq_cnt - SEQ_ONE;
          end
        end
        ST_HALT: halted = 1'b1;
        default: next_state = ST_RUN;
      endcase
    end
  end

endmodule
